// File: rtl/cmos_frame_pkg.sv
// Shared types and constants for the CMOS frame-buffer index controller.
package cmos_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cmos_frame_index_ctrl_if.sv
// Writer/reader handshake bundle of the frame index controller.
// The controller drives the master modport; the frame writer and reader sit on slave.
interface cmos_frame_index_ctrl_if #(
  parameter int IDX_W = 2
);
  import cmos_frame_pkg::*;

  logic             write_req;
  logic             write_req_ack;
  logic             read_lock;
  logic [IDX_W-1:0] write_addr_index;
  logic [IDX_W-1:0] read_addr_index;
  logic             read_valid;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output write_req, write_addr_index, read_addr_index, read_valid,
           drop_cnt, frame_cnt,
    input  write_req_ack, read_lock
  );

  modport slave (
    input  write_req, write_addr_index, read_addr_index, read_valid,
           drop_cnt, frame_cnt,
    output write_req_ack, read_lock
  );

endinterface

// File: rtl/cmos_vsync_sync.sv
// Brings raw sensor vsync into the pclk domain and emits a one-cycle frame-edge pulse.
module cmos_vsync_sync #(
  parameter int SYNC_STAGES = 3,
  parameter int VSYNC_POL   = 1
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic cmos_vsync,
  output logic fe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cmos_vsync};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge is taken between the last synchroniser flop and the extra edge flop.
  assign fe = (VSYNC_POL != 0) ? ( sync_q[SYNC_STAGES-1] & ~edge_q)
                               : (~sync_q[SYNC_STAGES-1] &  edge_q);

endmodule

// File: rtl/cmos_frame_index_ctrl.sv
// Triple(+)-buffer frame index controller: hands the writer a free buffer each frame
// and never reuses the buffer the reader has locked. Macro CMOS_FRAME_STATS_EN adds drop/frame counters.
module cmos_frame_index_ctrl
  import cmos_frame_pkg::*;
#(
  parameter int NUM_BUF     = 3,
  parameter int IDX_W       = 2,
  parameter int SYNC_STAGES = 3,
  parameter int VSYNC_POL   = 1
) (
  input  logic                   pclk,
  input  logic                   rst_n,
  input  logic                   cmos_vsync,
  cmos_frame_index_ctrl_if.master bus
);

  localparam logic [IDX_W:0] NB = (IDX_W+1)'(NUM_BUF);

  logic             fe;
  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] lock_idx;
  logic             lock_valid;
  logic             rd_valid;
  logic             lock_take;
  logic             frame_done;
  logic             cmp_valid;
  logic [IDX_W-1:0] cmp_idx;
  logic [IDX_W-1:0] inc1_idx;
  logic [IDX_W-1:0] nxt_idx;

  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] cur,
                                               input logic [1:0]       step);
    logic [IDX_W:0] sum;
    sum = {1'b0, cur} + {{(IDX_W-1){1'b0}}, step};
    if (sum >= NB) sum = sum - NB;
    return sum[IDX_W-1:0];
  endfunction

  cmos_vsync_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .VSYNC_POL   (VSYNC_POL)
  ) u_vsync_sync (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .cmos_vsync (cmos_vsync),
    .fe         (fe)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fe) state_nxt = REQ;
      REQ:     if (bus.write_req_ack) state_nxt = ACTIVE;
      ACTIVE:  if (fe) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.write_req = (state == REQ);

  assign lock_take  = bus.read_lock & rd_valid;
  assign frame_done = (state == ACTIVE) & fe;

  // A lock arriving on the same edge as a frame completion must already steer the skip.
  assign cmp_valid = lock_valid | lock_take;
  assign cmp_idx   = lock_take ? rd_idx : lock_idx;
  assign inc1_idx  = idx_add(wr_idx, 2'd1);
  assign nxt_idx   = (cmp_valid && (inc1_idx == cmp_idx)) ? idx_add(wr_idx, 2'd2) : inc1_idx;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      rd_valid   <= 1'b0;
      lock_idx   <= '0;
      lock_valid <= 1'b0;
    end else begin
      if (frame_done) begin
        rd_idx   <= wr_idx;
        rd_valid <= 1'b1;
        wr_idx   <= nxt_idx;
      end
      if (lock_take) begin
        lock_idx   <= rd_idx;
        lock_valid <= 1'b1;
      end
    end
  end

  assign bus.write_addr_index = wr_idx;
  assign bus.read_addr_index  = rd_idx;
  assign bus.read_valid       = rd_valid;

`ifdef CMOS_FRAME_STATS_EN
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] frame_q;
  logic             drop_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Ack wins over a coincident edge, so that case is not a drop.
  assign drop_evt = (state == REQ) & fe & ~bus.write_req_ack;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q  <= '0;
      frame_q <= '0;
    end else begin
      if (drop_evt)   drop_q  <= sat_inc(drop_q);
      if (frame_done) frame_q <= sat_inc(frame_q);
    end
  end

  assign bus.drop_cnt  = drop_q;
  assign bus.frame_cnt = frame_q;
`else
  assign bus.drop_cnt  = '0;
  assign bus.frame_cnt = '0;
`endif

endmodule

// File: tb/tb_cmos_frame_index_ctrl.sv
// Directed + randomized bench for cmos_frame_index_ctrl against a transaction-level buffer model.
module tb_cmos_frame_index_ctrl;
  import cmos_frame_pkg::*;

  localparam int NUM_BUF     = 3;
  localparam int IDX_W       = 2;
  localparam int SYNC_STAGES = 3;
  localparam int VSYNC_POL   = 1;
`ifdef CMOS_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic cmos_vsync = 1'b0;

  always #5 pclk = ~pclk;

  cmos_frame_index_ctrl_if #(.IDX_W(IDX_W)) bus ();

  cmos_frame_index_ctrl #(
    .NUM_BUF     (NUM_BUF),
    .IDX_W       (IDX_W),
    .SYNC_STAGES (SYNC_STAGES),
    .VSYNC_POL   (VSYNC_POL)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .cmos_vsync (cmos_vsync),
    .bus        (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: phase 0 = no frame yet, 1 = request outstanding, 2 = writer busy on m_wr.
  int m_phase, m_wr, m_rd, m_locki, m_drops, m_frames;
  bit m_lockv, m_rdv;
  bit hist[$];

  task automatic model_reset();
    m_phase = 0; m_wr = 0; m_rd = 0; m_locki = 0; m_lockv = 0; m_rdv = 0;
    m_drops = 0; m_frames = 0;
    hist = {};
    repeat (SYNC_STAGES + 1) hist.push_back(1'b0);
  endtask

  task automatic model_step(input bit vs, input bit ack, input bit lk);
    bit a, b, fe, lock_now, eff_v;
    int eff_i, n, old_rd;
    hist.push_back(vs);
    if (hist.size() > SYNC_STAGES + 2) void'(hist.pop_front());
    // the edge the controller acts on now is the one sampled SYNC_STAGES clocks ago
    a  = hist[hist.size() - 1 - SYNC_STAGES];
    b  = hist[hist.size() - 2 - SYNC_STAGES];
    fe = (VSYNC_POL != 0) ? (a && !b) : (!a && b);
    old_rd   = m_rd;
    lock_now = lk && m_rdv;
    eff_v    = m_lockv || lock_now;
    eff_i    = lock_now ? old_rd : m_locki;
    case (m_phase)
      0: if (fe) m_phase = 1;
      1: begin
        if (ack) m_phase = 2;
        else if (fe) m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
      end
      default: if (fe) begin
        m_frames = (m_frames < 65535) ? m_frames + 1 : 65535;
        m_rd  = m_wr;
        m_rdv = 1'b1;
        n = (m_wr + 1) % NUM_BUF;
        if (eff_v && n == eff_i) n = (m_wr + 2) % NUM_BUF;
        m_wr = n;
        m_phase = 1;
      end
    endcase
    if (lock_now) begin
      m_lockv = 1'b1;
      m_locki = old_rd;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    assert (obs === 32'(exp)) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_all();
    check("write_req",        32'(bus.write_req),        (m_phase == 1) ? 1 : 0);
    check("write_addr_index", 32'(bus.write_addr_index), m_wr);
    check("read_addr_index",  32'(bus.read_addr_index),  m_rd);
    check("read_valid",       32'(bus.read_valid),       int'(m_rdv));
    check("drop_cnt",         32'(bus.drop_cnt),         STATS ? m_drops : 0);
    check("frame_cnt",        32'(bus.frame_cnt),        STATS ? m_frames : 0);
  endtask

  task automatic step();
    @(posedge pclk);
    model_step(cmos_vsync, bus.write_req_ack, bus.read_lock);
    @(negedge pclk);
    check_all();
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic vpulse();
    cmos_vsync = 1'b1; cycles(4);
    cmos_vsync = 1'b0; cycles(4);
  endtask

  task automatic ack_pulse();
    bus.write_req_ack = 1'b1; step();
    bus.write_req_ack = 1'b0; step();
  endtask

  task automatic lock_pulse();
    bus.read_lock = 1'b1; step();
    bus.read_lock = 1'b0; step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmos_vsync = 1'b0;
    bus.write_req_ack = 1'b0;
    bus.read_lock = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge pclk);
      check_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.write_req_ack = 1'b0;
    bus.read_lock = 1'b0;
    do_reset();

    // Latency from a vsync rise sampled on edge 1 to write_req
    cmos_vsync = 1'b1;
    step(); check("lat_edge1", 32'(bus.write_req), 0);
    step();
    step(); check("lat_edge3", 32'(bus.write_req), 0);
    step(); check("lat_edge4", 32'(bus.write_req), 1);
    cycles(2);
    cmos_vsync = 1'b0;
    cycles(2);

    // Three frames, writer acks two cycles after each request
    ack_pulse();
    vpulse(); ack_pulse();
    check("seq_rd_after2", 32'(bus.read_addr_index), 0);
    check("seq_rv_after2", 32'(bus.read_valid), 1);
    vpulse(); ack_pulse();
    check("seq_wr3", 32'(bus.write_addr_index), 2);
    check("seq_rd3", 32'(bus.read_addr_index), 1);
    check("seq_frames", 32'(bus.frame_cnt), STATS ? 2 : 0);

    // Unacknowledged request absorbs three more frame edges as drops
    do_reset();
    vpulse();
    vpulse(); vpulse(); vpulse();
    check("drop_req", 32'(bus.write_req), 1);
    check("drop_idx", 32'(bus.write_addr_index), 0);
    check("drop_cnt3", 32'(bus.drop_cnt), STATS ? 3 : 0);

    // Asynchronous reset while a request is pending
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_req",  32'(bus.write_req), 0);
    check("arst_drop", 32'(bus.drop_cnt), 0);
    check_all();
    @(negedge pclk);
    rst_n = 1'b1;
    vpulse();
    check("arst_next_req", 32'(bus.write_req), 1);
    check("arst_next_idx", 32'(bus.write_addr_index), 0);

    // Locked buffer is skipped when choosing the next write buffer
    do_reset();
    vpulse(); ack_pulse();
    vpulse(); ack_pulse();
    lock_pulse();
    vpulse(); ack_pulse();
    vpulse(); ack_pulse();
    check("skip_pre_wr", 32'(bus.write_addr_index), 1);
    check("skip_pre_rd", 32'(bus.read_addr_index), 2);
    lock_pulse();
    vpulse();
    check("skip_wr0", 32'(bus.write_addr_index), 0);
    ack_pulse();

    // Lock coincident with a frame completion steers that same index choice
    lock_pulse();
    vpulse(); ack_pulse();
    check("byp_pre_wr", 32'(bus.write_addr_index), 2);
    check("byp_pre_rd", 32'(bus.read_addr_index), 0);
    cmos_vsync = 1'b1;
    cycles(3);
    bus.read_lock = 1'b1; step();
    bus.read_lock = 1'b0;
    check("byp_wr1", 32'(bus.write_addr_index), 1);
    check("byp_rd2", 32'(bus.read_addr_index), 2);
    cmos_vsync = 1'b0;
    cycles(4);
    ack_pulse();

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) cmos_vsync = ~cmos_vsync;
      bus.write_req_ack = ($urandom_range(0, 3) == 0);
      bus.read_lock     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end
    bus.write_req_ack = 1'b0;
    bus.read_lock = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cmos_frame_index_ctrl.md
CMOS_FRAME_INDEX_CTRL -- requirements
Module: cmos_frame_index_ctrl

Interface
REQ-001 Parameter NUM_BUF, default 3: number of frame buffers; legal range 3..8.
REQ-002 Parameter IDX_W, default 2: index width; SHALL equal $clog2(NUM_BUF).
REQ-003 Parameter SYNC_STAGES, default 3: vsync synchroniser depth; legal range 2..4.
REQ-004 Parameter VSYNC_POL, default 1: 1 = rising vsync edge starts a frame, 0 = falling edge.
REQ-005 pclk  in  1  sole clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cmos_vsync  in  1  raw sensor vsync, asynchronous to pclk.
REQ-008 write_req_ack  in  1  writer accepts the pending request.
REQ-009 read_lock  in  1  one-cycle pulse; reader latches read_addr_index as its current buffer.
REQ-010 write_req  out  1  frame-write request, held until acknowledged.
REQ-011 write_addr_index  out  IDX_W  buffer the writer fills.
REQ-012 read_addr_index  out  IDX_W  most recently completed buffer.
REQ-013 read_valid  out  1  at least one frame has completed since reset.
REQ-014 drop_cnt  out  16  dropped-frame count (see Configuration).
REQ-015 frame_cnt  out  16  completed-frame count (see Configuration).

Function
REQ-016 The block SHALL sync cmos_vsync through SYNC_STAGES flops plus one edge flop; frame-edge pulse fe = edge of polarity VSYNC_POL between the last two flops.
REQ-017 Latency: an active vsync edge first sampled on pclk edge 1 SHALL raise write_req on edge SYNC_STAGES+1.
REQ-018 FSM states: IDLE, REQ, ACTIVE; reset state IDLE.
REQ-019 IDLE: fe -> REQ, write_req=1, write_addr_index unchanged.
REQ-020 REQ: write_req_ack=1 -> ACTIVE, write_req=0; ack SHALL take priority over a simultaneous fe (no drop).
REQ-021 REQ: fe without ack -> stay REQ, write_req held, index unchanged, drop_cnt += 1.
REQ-022 ACTIVE: fe -> REQ; read_addr_index <= write_addr_index; read_valid <= 1; frame_cnt += 1; write_addr_index <= next index (REQ-023).
REQ-023 Next index = (cur+1) mod NUM_BUF; if lock_valid and equal to lock_idx, use (cur+2) mod NUM_BUF.
REQ-024 read_lock: lock_idx <= read_addr_index (pre-update value), lock_valid <= 1; ignored while read_valid=0.
REQ-025 read_lock coincident with an ACTIVE fe: REQ-023 SHALL compare against the value being locked that cycle (bypass).
REQ-026 write_req_ack outside REQ SHALL be ignored.
REQ-027 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-028 write_addr_index SHALL never equal lock_idx while lock_valid=1 after any ACTIVE fe.

Reset
REQ-029 rst_n low SHALL immediately clear sync chain, FSM (IDLE), write_req, both indices, lock_idx, lock_valid, read_valid, drop_cnt, frame_cnt to 0.
REQ-030 Reset mid-frame SHALL abandon any pending request; first fe after release behaves as from IDLE.

Configuration
REQ-031 Macro CMOS_FRAME_STATS_EN defined: drop_cnt and frame_cnt implemented per REQ-021/022/027.
REQ-032 Macro undefined: drop_cnt and frame_cnt tied to 0, no counter flops; all other behaviour identical.

Structure
REQ-033 Package cmos_frame_pkg SHALL hold the FSM state enum, counter width (16) and saturation constant.
REQ-034 Sub-module cmos_vsync_sync SHALL implement REQ-016 (parameters SYNC_STAGES, VSYNC_POL; output fe).

Verification
REQ-035 Reset, 3 vsync pulses, ack 2 cycles after each write_req: write_addr_index 0->1->2, read_addr_index 0->1, read_valid 1 after second fe.
REQ-036 SYNC_STAGES=3, vsync rises before edge 1: write_req high after edge 4, not after edge 3.
REQ-037 No ack, 3 fe in REQ: write_req stays 1, index unchanged, drop_cnt=3 (macro on) / 0 (macro off).
REQ-038 NUM_BUF=3, writing idx 1, read_lock with read_addr_index=2, then fe: write_addr_index=0 (2 skipped).
REQ-039 read_lock and ACTIVE fe same cycle, read_addr_index=0, write idx 2: lock_idx=0, write_addr_index=1.
REQ-040 rst_n low while REQ with write_req=1: all outputs 0 same cycle; next fe gives write_req with index 0.
